// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: host-loaded job queue that issues (op, A, B) jobs in order
// to the ALU control unit, captures each result with its flags and reports
// completion. Optional WAIT timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter int DEPTH          = 8,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_op,
  input  logic [WIDTH-1:0] wr_a,
  input  logic [WIDTH-1:0] wr_b,
  output logic             full,
  input  logic             run,
  output logic             start,
  output logic [2:0]       op_select,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  input  logic             ctrl_busy,
  input  logic             ctrl_result_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zero_flag,
  input  logic             carry_flag,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_carry,
  output logic [2:0]       res_index,
  output logic             done,
  output logic             seq_busy,
  output logic             error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("alu_op_sequencer: unsupported DEPTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t           state;
  logic [2:0]       q_op [DEPTH];
  logic [WIDTH-1:0] q_a  [DEPTH];
  logic [WIDTH-1:0] q_b  [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    ptr;
  logic [CW-1:0]    ptr_next;
  logic [CW-1:0]    count_eff;
  logic             wr_accept;
  logic             run_accept;
  logic             timeout_hit;
  logic [2:0]       first_op;
  logic [WIDTH-1:0] first_a;
  logic [WIDTH-1:0] first_b;

  // Queue acceptance and the job that a run starts with; a write in the run
  // cycle is folded in so it takes part in that run.
  always_comb begin
    wr_accept  = (state == S_IDLE) && wr_en && (count != CW'(DEPTH));
    count_eff  = count + CW'(wr_accept);
    run_accept = (state == S_IDLE) && run && (count_eff != '0);
    ptr_next   = ptr + CW'(1);
    first_op   = (count == '0) ? wr_op : q_op[0];
    first_a    = (count == '0) ? wr_a  : q_a[0];
    first_b    = (count == '0) ? wr_b  : q_b[0];
  end

  assign full     = (count == CW'(DEPTH));
  assign seq_busy = (state != S_IDLE);
  // Request is combinational so a freed control unit is served in the same cycle.
  assign start    = (state == S_ISSUE) && !ctrl_busy;

  // Job storage; contents are don't-care beyond count, so no reset needed.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept) begin
      q_op[count[AW-1:0]] <= wr_op;
      q_a[count[AW-1:0]]  <= wr_a;
      q_b[count[AW-1:0]]  <= wr_b;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign timeout_hit = (state == S_WAIT) && !ctrl_result_valid &&
                       (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter (zero on entry) and sticky error, cleared by a new run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt  <= '0;
      error <= 1'b0;
    end else begin
      tcnt <= (state == S_WAIT) ? tcnt + TW'(1) : '0;
      if (run_accept)
        error <= 1'b0;
      else if (timeout_hit)
        error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // Sequencer FSM with registered job/result outputs and strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      ptr       <= '0;
      op_select <= '0;
      operand_a <= '0;
      operand_b <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_index <= '0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_accept)
            count <= count_eff;
          if (run_accept) begin
            state     <= S_ISSUE;
            ptr       <= '0;
            op_select <= first_op;
            operand_a <= first_a;
            operand_b <= first_b;
          end else if (run) begin
            done <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!ctrl_busy)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (ctrl_result_valid) begin
            res_valid <= 1'b1;
            res_data  <= alu_result;
            res_zero  <= zero_flag;
            res_carry <= carry_flag;
            res_index <= 3'(ptr);
            if (ptr == count - CW'(1)) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              // Next job's operands are loaded here so they are valid during its ISSUE.
              ptr       <= ptr_next;
              state     <= S_ISSUE;
              op_select <= q_op[ptr_next[AW-1:0]];
              operand_a <= q_a[ptr_next[AW-1:0]];
              operand_b <= q_b[ptr_next[AW-1:0]];
            end
          end else if (timeout_hit) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end
        end
        S_FINISH: begin
          count <= '0;
          ptr   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a 3-cycle ALU responder model.
module tb_alu_op_sequencer;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } job_t;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
    logic       z;
    logic       c;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_op = '0;
  logic [7:0] wr_a = '0;
  logic [7:0] wr_b = '0;
  logic       full;
  logic       run = 1'b0;
  logic       start;
  logic [2:0] op_select;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       resp_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       ctrl_busy;
  logic       ctrl_result_valid = 1'b0;
  logic [7:0] alu_result = '0;
  logic       zero_flag = 1'b0;
  logic       carry_flag = 1'b0;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_zero;
  logic       res_carry;
  logic [2:0] res_index;
  logic       done;
  logic       seq_busy;
  logic       error;

  assign ctrl_busy = resp_busy | hold_busy;

  alu_op_sequencer #(.DEPTH(8), .WIDTH(8), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_op(wr_op), .wr_a(wr_a), .wr_b(wr_b),
    .full(full), .run(run), .start(start), .op_select(op_select),
    .operand_a(operand_a), .operand_b(operand_b), .ctrl_busy(ctrl_busy),
    .ctrl_result_valid(ctrl_result_valid), .alu_result(alu_result),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .res_valid(res_valid),
    .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry),
    .res_index(res_index), .done(done), .seq_busy(seq_busy), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int res_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit done_with_res = 1'b0;
  bit resp_silent = 1'b0;
  int qn = 0;
  int start_cyc[$];
  int res_cyc[$];
  job_t iq[$];
  res_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU: {carry, zero, result}
  function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b};
      3'd1:    s = {1'b0, a} - {1'b0, b};
      3'd2:    s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    return {s[8], (s[7:0] == 8'h00), s[7:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: busy from t+1, result strobe at t+3, released at t+4.
  initial begin
    logic [9:0] r;
    forever begin
      @(negedge clk);
      if (start && !resp_silent) begin
        r = alu_f(op_select, operand_a, operand_b);
        @(posedge clk); #1 resp_busy = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        ctrl_result_valid = 1'b1;
        alu_result = r[7:0];
        zero_flag  = r[8];
        carry_flag = r[9];
        @(posedge clk); #1;
        ctrl_result_valid = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // Output monitor: issued jobs and captured results against the queues.
  initial begin
    job_t j;
    res_t e;
    forever begin
      @(negedge clk);
      if (start) begin
        start_cyc.push_back(cyc);
        if (iq.size() == 0) check("start_unexpected", 1, 0);
        else begin
          j = iq.pop_front();
          check("op_select", 32'(op_select), 32'(j.op));
          check("operand_a", 32'(operand_a), 32'(j.a));
          check("operand_b", 32'(operand_b), 32'(j.b));
        end
      end
      if (res_valid) begin
        res_cnt++;
        res_cyc.push_back(cyc);
        if (sb.size() == 0) check("res_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("res_index", 32'(res_index), 32'(e.idx));
          check("res_data",  32'(res_data),  32'(e.data));
          check("res_zero",  32'(res_zero),  32'(e.z));
          check("res_carry", 32'(res_carry), 32'(e.c));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_with_res = res_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_job(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input bit accepted, input bit exp_res);
    logic [9:0] r;
    job_t j;
    res_t e;
    wr_en = 1'b1; wr_op = op; wr_a = a; wr_b = b;
    tick();
    wr_en = 1'b0;
    if (accepted) begin
      r = alu_f(op, a, b);
      j.op = op; j.a = a; j.b = b;
      iq.push_back(j);
      if (exp_res) begin
        e.idx = 3'(qn); e.data = r[7:0]; e.z = r[8]; e.c = r[9];
        sb.push_back(e);
      end
      qn++;
    end
  endtask

  task automatic run_pulse();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      tick();
      i++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    qn = 0;
  endtask

  initial begin
    int b, r, rc, s0, d0;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r, rc, s0, d0;
    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_outputs", {start, res_valid, done, seq_busy, error, full, res_zero, res_carry},  8'h00);
    check("rst_data", {op_select, operand_a, operand_b, res_data, res_index}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic 3-job run
    write_job(3'd0, 8'h05, 8'h03, 1, 1);
    write_job(3'd1, 8'h10, 8'h01, 1, 1);
    write_job(3'd2, 8'hFF, 8'h01, 1, 1);
    b = start_cyc.size(); r = res_cyc.size(); rc = res_cnt;
    run_pulse();
    wait_done(100);
    check("basic_res_count", res_cnt - rc, 3);
    check("basic_start_gap1", start_cyc[b+1] - start_cyc[b], 4);
    check("basic_start_gap2", start_cyc[b+2] - start_cyc[b+1], 4);
    check("basic_first_latency", res_cyc[r] - start_cyc[b], 4);
    check("basic_done_with_res", 32'(done_with_res), 1);
    check("basic_seq_busy_after", 32'(seq_busy), 0);
    check("hold_operands", {op_select, operand_a, operand_b}, {3'd2, 8'hFF, 8'h01});

    // Full queue: 9th write dropped
    for (int i = 0; i < 9; i++) begin
      logic [7:0] a;
      a = 8'($urandom);
      write_job(3'(i), a, (i == 3) ? a : 8'($urandom), (i < 8), 1);
      if (i == 6) check("full_at_7", 32'(full), 0);
      if (i >= 7) check("full_at_8", 32'(full), 1);
    end
    rc = res_cnt;
    run_pulse();
    wait_done(200);
    check("full_res_count", res_cnt - rc, 8);
    check("full_after_run", 32'(full), 0);

    // Busy hold at ISSUE
    write_job(3'd0, 8'hA5, 8'h5A, 1, 1);
    write_job(3'd3, 8'h33, 8'h0F, 1, 1);
    hold_busy = 1'b1;
    run_pulse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_start_low", 32'(start), 0);
      tick();
    end
    hold_busy = 1'b0;
    @(negedge clk);
    check("busy_start_release", 32'(start), 1);
    check("busy_operands", {op_select, operand_a, operand_b}, {3'd0, 8'hA5, 8'h5A});
    tick();
    wait_done(100);

    // Empty run
    run_pulse();
    @(negedge clk);
    check("empty_done", 32'(done), 1);
    check("empty_no_start", 32'(start), 0);
    tick();

    // Writes and run during an active run are ignored
    write_job(3'd1, 8'h80, 8'h81, 1, 1);
    write_job(3'd0, 8'h80, 8'h80, 1, 1);
    rc = res_cnt;
    run_pulse();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_op = 3'd7; wr_a = 8'hEE; wr_b = 8'hEE; run = 1'b1;
      tick();
    end
    wr_en = 1'b0; run = 1'b0;
    wait_done(100);
    check("ignored_res_count", res_cnt - rc, 2);
    run_pulse();
    @(negedge clk);
    check("ignored_count_zero_done", 32'(done), 1);
    check("ignored_count_zero_start", 32'(start), 0);
    tick();

    // Reset in WAIT of job 1
    write_job(3'd0, 8'h01, 8'h02, 1, 1);
    write_job(3'd1, 8'h03, 8'h04, 1, 1);
    write_job(3'd2, 8'h05, 8'h06, 1, 1);
    s0 = start_cyc.size();
    run_pulse();
    for (int i = 0; i < 50 && start_cyc.size() < s0 + 2; i++) tick();
    check("rstmid_reached_job1", start_cyc.size() - s0, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    iq.delete(); sb.delete(); qn = 0;
    d0 = done_cnt;
    @(negedge clk);
    check("rstmid_outputs", {start, res_valid, done, seq_busy, error, full}, 6'h00);
    check("rstmid_data", {op_select, operand_a, operand_b, res_data, res_index}, 32'h0);
    tick();
    repeat (8) tick();
    check("rstmid_no_done", done_cnt - d0, 0);
    write_job(3'd3, 8'h77, 8'h70, 1, 1);
    rc = res_cnt;
    run_pulse();
    wait_done(100);
    check("rstmid_rerun_res", res_cnt - rc, 1);

`ifdef ALU_SEQ_TIMEOUT_EN
    // Responder never returns
    resp_silent = 1'b1;
    write_job(3'd0, 8'h11, 8'h22, 1, 0);
    b = start_cyc.size(); rc = res_cnt;
    run_pulse();
    wait_done(60);
    check("timeout_done_cycle", done_cyc - start_cyc[b], 16);
    check("timeout_error", 32'(error), 1);
    check("timeout_no_res", res_cnt - rc, 0);
    resp_silent = 1'b0;
    write_job(3'd0, 8'h01, 8'h01, 1, 1);
    run_pulse();
    check("timeout_error_cleared", 32'(error), 0);
    wait_done(100);
`endif

    check("error_final", 32'(error), 0);
    check("sb_empty", sb.size(), 0);
    check("iq_empty", iq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU control handshake: holds a small queue of (op, A, B) jobs loaded by the host.
- On `run`, issues each job in order to the ALU control unit (start / op_select / operands) and waits for its result_valid.
- Captures each result with its flags and presents it to the host as a one-cycle result strobe, then signals completion.
- Sits between the host/pin interface and the control+datapath pair.

Parameters:
- DEPTH, 8, job queue entries (power of 2, 2..8).
- WIDTH, 8, operand/result width.
- TIMEOUT_CYCLES, 15, WAIT cycles before abort (only with ALU_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- wr_en  in  1  host job write strobe.
- wr_op  in  3  job opcode.
- wr_a  in  WIDTH  job operand A.
- wr_b  in  WIDTH  job operand B.
- full  out  1  queue holds DEPTH jobs.
- run  in  1  start executing queued jobs.
- start  out  1  one-cycle request to control unit.
- op_select  out  3  opcode to control unit.
- operand_a  out  WIDTH  operand A to datapath.
- operand_b  out  WIDTH  operand B to datapath.
- ctrl_busy  in  1  control unit busy.
- ctrl_result_valid  in  1  control unit result strobe.
- alu_result  in  WIDTH  datapath result.
- zero_flag  in  1  datapath zero flag.
- carry_flag  in  1  datapath carry flag.
- res_valid  out  1  one-cycle captured-result strobe.
- res_data  out  WIDTH  captured result.
- res_zero  out  1  captured zero flag.
- res_carry  out  1  captured carry flag.
- res_index  out  3  queue index of captured job.
- done  out  1  one-cycle end-of-run strobe.
- seq_busy  out  1  run in progress.
- error  out  1  sticky timeout flag.

Interface decision: one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=IDLE; count=0; ptr=0.
  - Outputs: start, res_valid, done, seq_busy, error = 0; op_select, operand_a/b, res_data, res_index = 0; res_zero = 0; res_carry = 0; full = 0.
  - Reset mid-run aborts immediately, discards the queue and emits no done.
- Queue:
  - Write accepted only when state==IDLE, wr_en=1 and count<DEPTH. Entry stored at index count; count++.
  - Writes while full or not IDLE are dropped silently.
  - full = (count==DEPTH).
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - run=1 with count>0 -> ISSUE, ptr=0, error cleared.
  - run=1 with count==0 -> done pulses next cycle; stay IDLE.
  - run and wr_en in the same cycle: the write is taken first and is included in the run.
- ISSUE:
  - If ctrl_busy=0: start=1 for exactly this cycle; op_select/operand_a/operand_b driven from entry[ptr]; -> WAIT.
  - If ctrl_busy=1: start stays 0 and the sequencer remains in ISSUE.
- WAIT:
  - op_select/operand_a/operand_b held stable at entry[ptr].
  - On ctrl_result_valid=1: register alu_result, zero_flag, carry_flag and ptr into res_*; res_valid=1 the following cycle.
  - If ptr==count-1 -> FINISH, else ptr++ -> ISSUE.
- FINISH: done=1 for one cycle; count=0; ptr=0; -> IDLE.
- seq_busy = (state != IDLE).
- Ignored inputs: run outside IDLE; ctrl_result_valid outside WAIT.
- Latency against a 3-cycle responder (busy at t+1, result_valid at t+3):
  - start at t; res_valid at t+4; next start at t+4.
  - Steady state: one job per 4 cycles.
  - Final done is asserted in the same cycle as the last res_valid.
- Output holds: res_* hold their value between strobes; operand outputs hold their last job after the run.
- Arithmetic: no arithmetic on data; ptr/count are unsigned, $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT (reset on entry).
  - If TIMEOUT_CYCLES clocks elapse without ctrl_result_valid: error=1 (sticky until next accepted run or reset); no res_valid for that job; -> FINISH (done pulses, queue cleared).
  - A result_valid arriving in the same cycle as expiry wins; no error is set.
- Undefined: WAIT indefinitely; error tied 0; no counter logic.

Test Plan:
- Basic run: write 3 jobs (op 0, A=5, B=3; op 1, A=0x10, B=0x01; op 2, A=0xFF, B=0x01); pulse run; model responder at 3 cycles.
  -> start pulses at cycles t, t+4, t+8; res_valid with res_index 0,1,2; done coincident with the third res_valid; seq_busy low after.
- Full queue: write 9 jobs.
  -> full=1 after the 8th write; the 9th is dropped; run yields exactly 8 res_valid, res_index 0..7.
- Busy hold: hold ctrl_busy=1 for 5 cycles at ISSUE.
  -> start stays 0 throughout; start asserts in the first cycle after ctrl_busy=0; operands equal entry[ptr].
- Empty run / ignored inputs:
  - run with count=0 -> done pulse next cycle, no start.
  - wr_en and run during an active run -> ignored, count unchanged.
- Reset mid-WAIT: rst_n=0 for one edge at job 1 of 3.
  -> all outputs 0, count=0, no done; a new 1-job run completes normally.
- With ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=15: responder never returns.
  -> error=1 and done pulse 15 cycles after entering WAIT, no res_valid.
  -> the next run clears error.
